memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Pipeline stage directly downstream of execute: consumes ALU result, Rsrc value, next-PC, in-port and control bits.
//  Performs data-memory LDD/STD, stack PUSH/POP, and multi-word CALL/RET/RTI via an owned stack pointer.
//  Drives the MEM/WB pipeline register, which is also the memory-stage forwarding source for execute.
//  Raises Stall to freeze upstream during the extra iterations of multi-word ops.
// PARAMETERS
//  ADDR_W   20                 data-memory word-address width
//  SP_INIT  (1<<ADDR_W)-2      stack pointer value after reset; stack grows downward
// PORTS
//  CLK          in   1      clock, rising edge
//  Reset        in   1      asynchronous, active-low reset
//  AluResult    in   16     execute ALU output; LDD/STD effective address
//  RsrcVal      in   16     store/push data
//  NextPC       in   32     return address for CALL
//  InPort       in   16     IN-instruction data
//  RdstAddr     in   3      destination register
//  FlagsIn      in   3      {ZF,NF,CF} current flags; pushed by CALL-on-interrupt (IntCall)
//  Push,Pop,Call,IntCall,Ret,Rti,Ldd,Std,In,WbIn  in 1 each   decoded controls from execute
//  DMemAddr     out  ADDR_W data-memory address (combinational)
//  DMemWData    out  16     write data (combinational)
//  DMemWr       out  1      write strobe; memory writes on CLK rising edge
//  DMemRData    in   16     read data; combinational from DMemAddr
//  Stall        out  1      combinational; high = upstream holds inputs stable
//  WbEn,WbAddr(3),WbData(16)   out   registered MEM/WB; WbEn/WbAddr/WbData also feed execute forwarding
//  PcLoad(1),PcValue(32)       out   registered; PC redirect for RET/RTI
//  FlagsLoad(1),FlagsOut(3)    out   registered; flag restore for RTI
// BEHAVIOUR
//  - Reset low: FSM=IDLE, SP=SP_INIT, all registered outputs 0. Takes effect immediately, including mid multi-word op; that op is abandoned.
//  - Single-word ops: one cycle; result registered at the closing edge.
//    * LDD: addr=AluResult[ADDR_W-1:0] zero-extended; WbData=DMemRData.
//    * STD: same addr; DMemWData=RsrcVal.
//    * PUSH: write RsrcVal @SP, then SP-=1.
//    * POP: read @SP+1, then SP+=1; WbData=read data.
//    * IN: WbData=InPort.
//    * Otherwise: WbData=AluResult.
//    * WbEn=WbIn for all single-word ops.
//  - FSM states IDLE, IT2, IT3. Stall=1 in every cycle of a multi-word op except its last. WbEn=0 throughout.
//    * CALL:    IDLE writes NextPC[31:16] @SP -> IT2 writes NextPC[15:0] @SP-1 -> IDLE. SP-=2 total.
//    * IntCall: as CALL, plus IT3 writes {13'b0,FlagsIn} @SP-2. SP-=3.
//    * RET:     IDLE reads @SP+1 (low half, held in shadow reg) -> IT2 reads @SP+2 (high half).
//               Then PcLoad=1 for one cycle with PcValue={high,low}. SP+=2.
//    * RTI:     IDLE reads flags @SP+1 -> IT2 reads low half -> IT3 reads high half.
//               Then PcLoad=FlagsLoad=1 for one cycle; FlagsOut=flags word[2:0]. SP+=3.
//  - SP arithmetic is modulo 2^ADDR_W: wrap silently, no overflow/underflow flag.
//  - Simultaneous controls: priority Rti>Ret>IntCall>Call>Push>Pop>Std>Ldd. Lower-priority controls are ignored.
//  - Inputs are sampled only in IDLE. IT2/IT3 use values latched at the IDLE cycle.
//  - PcLoad and FlagsLoad are single-cycle pulses; 0 otherwise. DMemWr is never high in a read cycle.
// STRUCTURE
//  - Package mem_stage_pkg: FSM state encoding (2-bit), op-select enum, SP_INIT default, flag bit indices.
//  - Sub-module stack_pointer_unit: SP register, inc/dec by 1, address mux for SP/SP+1/SP+2/SP-1/SP-2.
//  - Top: FSM, shadow regs (low half, flags), data mux, MEM/WB register.
// TESTING
//  1. Reset low mid-CALL (state IT2) -> next cycle all outputs 0, Stall=0, SP=SP_INIT.
//  2. Std, AluResult=0x0040, RsrcVal=0xBEEF; then Ldd same addr, RdstAddr=3 -> WbEn=1, WbAddr=3, WbData=0xBEEF.
//  3. Call, NextPC=0x0001_2345, SP=0xFFFFE:
//     -> mem[0xFFFFE]=0x0001, mem[0xFFFFD]=0x2345, Stall high 1 cycle, SP=0xFFFFC.
//     Then Ret -> PcLoad=1, PcValue=0x0001_2345, SP=0xFFFFE.
//  4. IntCall with FlagsIn=3'b101, then Rti -> Stall high 2 cycles each; PcLoad=FlagsLoad=1, FlagsOut=3'b101.
//  5. SP=0xFFFFF, Pop -> reads addr 0x00000 (wrap), SP=0x00000. Push then Pop of 0x1234 -> WbData=0x1234.
//  6. Push and Pop asserted together with RsrcVal=0x0A0A -> only the push occurs; SP-=1; WbEn follows WbIn, WbData=AluResult.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM encoding, op select, stack-pointer controls.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int ADDR_W_DEF = 20;

    // Flag word layout {ZF,NF,CF}
    localparam int FLAG_W  = 3;
    localparam int FLAG_CF = 0;
    localparam int FLAG_NF = 1;
    localparam int FLAG_ZF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IT2  = 2'd1,
        ST_IT3  = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_IN,
        OP_LDD,
        OP_STD,
        OP_POP,
        OP_PUSH,
        OP_CALL,
        OP_INTCALL,
        OP_RET,
        OP_RTI
    } op_e;

    typedef enum logic [1:0] {
        SP_HOLD,
        SP_INC,
        SP_DEC
    } sp_step_e;

    // Stack address is either the current top (writes) or the slot above it (reads)
    typedef enum logic {
        SP_SEL_TOP,
        SP_SEL_ABOVE
    } sp_sel_e;

    // Stack starts two words below the top of the address space
    function automatic logic [31:0] sp_init_default(input int aw);
        return (32'd1 << aw) - 32'd2;
    endfunction

    // Resolve simultaneous controls; lower-priority ones are dropped
    function automatic op_e decode_op(
        input logic rti, input logic ret, input logic intcall, input logic call,
        input logic push, input logic pop, input logic std, input logic ldd,
        input logic in_c
    );
        op_e op;
        if (rti)          op = OP_RTI;
        else if (ret)     op = OP_RET;
        else if (intcall) op = OP_INTCALL;
        else if (call)    op = OP_CALL;
        else if (push)    op = OP_PUSH;
        else if (pop)     op = OP_POP;
        else if (std)     op = OP_STD;
        else if (ldd)     op = OP_LDD;
        else if (in_c)    op = OP_IN;
        else              op = OP_NONE;
        return op;
    endfunction

    function automatic logic is_multi(input op_e op);
        return (op == OP_CALL) || (op == OP_INTCALL) || (op == OP_RET) || (op == OP_RTI);
    endfunction

endpackage

// File: rtl/memory_stage_stack_pointer_unit.sv
// Stack pointer register with +/-1 stepping and top/above address select.
// Latency: address is combinational from SP; SP updates on the clock edge.
// Backpressure: none; the owner decides when to step.
module stack_pointer_unit
    import mem_stage_pkg::*;
#(
    parameter int                 ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  SP_INIT = ADDR_W'(sp_init_default(ADDR_W))
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  sp_step_e          step_i,
    input  sp_sel_e           sel_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;

    // Next SP: modulo arithmetic, wraps silently in both directions
    always_comb begin
        sp_d = sp_q;
        case (step_i)
            SP_INC:  sp_d = sp_q + ADDR_W'(1);
            SP_DEC:  sp_d = sp_q - ADDR_W'(1);
            default: sp_d = sp_q;
        endcase
    end

    // SP register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sp_q <= SP_INIT;
        else          sp_q <= sp_d;
    end

    assign addr_o = (sel_i == SP_SEL_ABOVE) ? sp_q + ADDR_W'(1) : sp_q;

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: LDD/STD, PUSH/POP and multi-word CALL/INTCALL/RET/RTI, MEM/WB register.
// Latency: single-word ops 1 cycle; CALL/RET 2 cycles, INTCALL/RTI 3 cycles; results registered.
// Backpressure: stall_o held high (combinationally) on all but the last cycle of a multi-word op.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(sp_init_default(ADDR_W))
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [15:0]       alu_result_i,
    input  logic [15:0]       rsrc_val_i,
    input  logic [31:0]       next_pc_i,
    input  logic [15:0]       in_port_i,
    input  logic [2:0]        rdst_addr_i,
    input  logic [FLAG_W-1:0] flags_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              call_i,
    input  logic              int_call_i,
    input  logic              ret_i,
    input  logic              rti_i,
    input  logic              ldd_i,
    input  logic              std_i,
    input  logic              in_i,
    input  logic              wb_in_i,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [15:0]       dmem_wdata_o,
    output logic              dmem_wr_o,
    input  logic [15:0]       dmem_rdata_i,
    output logic              stall_o,
    output logic              wb_en_o,
    output logic [2:0]        wb_addr_o,
    output logic [15:0]       wb_data_o,
    output logic              pc_load_o,
    output logic [31:0]       pc_value_o,
    output logic              flags_load_o,
    output logic [FLAG_W-1:0] flags_o
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;        // multi-word op latched in IDLE
    logic [15:0]       half_q, half_d;    // low PC half: NextPC for CALL, read data for RET/RTI
    logic [FLAG_W-1:0] flags_q, flags_d;  // FlagsIn for INTCALL, popped flags for RTI
    op_e               op_in;

    sp_step_e          sp_step;
    sp_sel_e           sp_sel;
    logic              use_stack;
    logic [ADDR_W-1:0] stack_addr;
    logic              final_ret;
    logic              final_rti;
    logic              wb_cap;
    logic [15:0]       wb_data_d;

    logic              wb_en_q;
    logic [2:0]        wb_addr_q;
    logic [15:0]       wb_data_q;
    logic              pc_load_q;
    logic [31:0]       pc_value_q;
    logic              flags_load_q;
    logic [FLAG_W-1:0] flags_out_q;

    assign op_in = decode_op(rti_i, ret_i, int_call_i, call_i, push_i, pop_i, std_i, ldd_i, in_i);

    stack_pointer_unit #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .step_i  (sp_step),
        .sel_i   (sp_sel),
        .addr_o  (stack_addr)
    );

    // FSM state and shadow registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
            half_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            half_q  <= half_d;
            flags_q <= flags_d;
        end
    end

    // Next state and shadow capture; inputs only matter in IDLE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        half_d  = half_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                op_d = op_in;
                if (is_multi(op_in)) state_d = ST_IT2;
                case (op_in)
                    OP_CALL:    half_d = next_pc_i[15:0];
                    OP_INTCALL: begin
                        half_d  = next_pc_i[15:0];
                        flags_d = flags_i;
                    end
                    OP_RET:     half_d = dmem_rdata_i;
                    OP_RTI:     flags_d = {dmem_rdata_i[FLAG_ZF], dmem_rdata_i[FLAG_NF], dmem_rdata_i[FLAG_CF]};
                    default:    ;
                endcase
            end
            ST_IT2: begin
                state_d = (op_q == OP_INTCALL || op_q == OP_RTI) ? ST_IT3 : ST_IDLE;
                if (op_q == OP_RTI) half_d = dmem_rdata_i;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory port, stack stepping and stall for the current cycle
    always_comb begin
        sp_step      = SP_HOLD;
        sp_sel       = SP_SEL_TOP;
        use_stack    = 1'b0;
        dmem_wr_o    = 1'b0;
        dmem_wdata_o = rsrc_val_i;
        stall_o      = 1'b0;
        final_ret    = 1'b0;
        final_rti    = 1'b0;
        wb_cap       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (op_in)
                    OP_RTI, OP_RET: begin
                        use_stack = 1'b1;
                        sp_sel    = SP_SEL_ABOVE;
                        sp_step   = SP_INC;
                        stall_o   = 1'b1;
                    end
                    OP_INTCALL, OP_CALL: begin
                        use_stack    = 1'b1;
                        dmem_wr_o    = 1'b1;
                        dmem_wdata_o = next_pc_i[31:16];
                        sp_step      = SP_DEC;
                        stall_o      = 1'b1;
                    end
                    OP_PUSH: begin
                        use_stack = 1'b1;
                        dmem_wr_o = 1'b1;
                        sp_step   = SP_DEC;
                        wb_cap    = 1'b1;
                    end
                    OP_POP: begin
                        use_stack = 1'b1;
                        sp_sel    = SP_SEL_ABOVE;
                        sp_step   = SP_INC;
                        wb_cap    = 1'b1;
                    end
                    OP_STD: begin
                        dmem_wr_o = 1'b1;
                        wb_cap    = 1'b1;
                    end
                    default: wb_cap = 1'b1;
                endcase
            end
            ST_IT2: begin
                use_stack = 1'b1;
                if (op_q == OP_CALL || op_q == OP_INTCALL) begin
                    dmem_wr_o    = 1'b1;
                    dmem_wdata_o = half_q;
                    sp_step      = SP_DEC;
                    stall_o      = (op_q == OP_INTCALL);
                end else begin
                    sp_sel    = SP_SEL_ABOVE;
                    sp_step   = SP_INC;
                    stall_o   = (op_q == OP_RTI);
                    final_ret = (op_q == OP_RET);
                end
            end
            ST_IT3: begin
                use_stack = 1'b1;
                if (op_q == OP_INTCALL) begin
                    dmem_wr_o    = 1'b1;
                    dmem_wdata_o = 16'(flags_q);
                    sp_step      = SP_DEC;
                end else begin
                    sp_sel    = SP_SEL_ABOVE;
                    sp_step   = SP_INC;
                    final_rti = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign dmem_addr_o = use_stack ? stack_addr : ADDR_W'(alu_result_i);

    // Write-back data select for single-word ops
    always_comb begin
        wb_data_d = alu_result_i;
        case (op_in)
            OP_POP, OP_LDD: wb_data_d = dmem_rdata_i;
            OP_IN:          wb_data_d = in_port_i;
            default:        wb_data_d = alu_result_i;
        endcase
    end

    // MEM/WB register plus PC/flag redirect pulses
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_en_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            pc_load_q    <= 1'b0;
            pc_value_q   <= '0;
            flags_load_q <= 1'b0;
            flags_out_q  <= '0;
        end else begin
            wb_en_q      <= wb_cap & wb_in_i;
            pc_load_q    <= final_ret | final_rti;
            flags_load_q <= final_rti;
            if (wb_cap) begin
                wb_addr_q <= rdst_addr_i;
                wb_data_q <= wb_data_d;
            end
            if (final_ret | final_rti) pc_value_q <= {dmem_rdata_i, half_q};
            if (final_rti)             flags_out_q <= flags_q;
        end
    end

    assign wb_en_o      = wb_en_q;
    assign wb_addr_o    = wb_addr_q;
    assign wb_data_o    = wb_data_q;
    assign pc_load_o    = pc_load_q;
    assign pc_value_o   = pc_value_q;
    assign flags_load_o = flags_load_q;
    assign flags_o      = flags_out_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage against a transaction-level stack/memory model.
// Latency: n/a.
// Backpressure: inputs held stable for the expected number of op cycles.
module tb_memory_stage;

    localparam int             AW  = 20;
    localparam logic [AW-1:0]  SP0 = 20'hFFFFE;

    typedef struct packed {
        logic rti, ret, intcall, call, push, pop, std, ldd, in_c, wbin;
    } ctl_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   alu_result, rsrc_val, in_port;
    logic [31:0]   next_pc;
    logic [2:0]    rdst_addr, flags_in;
    logic          push, pop, call, int_call, ret, rti, ldd, std, in_c, wb_in;
    logic [AW-1:0] dmem_addr;
    logic [15:0]   dmem_wdata, dmem_rdata;
    logic          dmem_wr, stall, wb_en, pc_load, flags_load;
    logic [2:0]    wb_addr, flags_out;
    logic [15:0]   wb_data;
    logic [31:0]   pc_value;

    int checks = 0;
    int errors = 0;

    // Environment memory written by the DUT; model memory is separate
    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] ref_mem [logic [AW-1:0]];
    logic [AW-1:0] ref_sp;

    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_wr) mem[dmem_addr] <= dmem_wdata;
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end

    memory_stage dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .alu_result_i (alu_result),
        .rsrc_val_i   (rsrc_val),
        .next_pc_i    (next_pc),
        .in_port_i    (in_port),
        .rdst_addr_i  (rdst_addr),
        .flags_i      (flags_in),
        .push_i       (push),
        .pop_i        (pop),
        .call_i       (call),
        .int_call_i   (int_call),
        .ret_i        (ret),
        .rti_i        (rti),
        .ldd_i        (ldd),
        .std_i        (std),
        .in_i         (in_c),
        .wb_in_i      (wb_in),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_wr_o    (dmem_wr),
        .dmem_rdata_i (dmem_rdata),
        .stall_o      (stall),
        .wb_en_o      (wb_en),
        .wb_addr_o    (wb_addr),
        .wb_data_o    (wb_data),
        .pc_load_o    (pc_load),
        .pc_value_o   (pc_value),
        .flags_load_o (flags_load),
        .flags_o      (flags_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mrd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic drive(input ctl_t c, input logic [15:0] alu, input logic [15:0] rsrc,
                         input logic [15:0] inp, input logic [31:0] npc,
                         input logic [2:0] rdst, input logic [2:0] flg);
        {rti, ret, int_call, call, push, pop, std, ldd, in_c, wb_in} = c;
        alu_result = alu; rsrc_val = rsrc; in_port = inp; next_pc = npc;
        rdst_addr = rdst; flags_in = flg;
    endtask

    task automatic idle_inputs();
        drive('0, 16'h0, 16'h0, 16'h0, 32'h0, 3'd0, 3'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/stall"},  32'(stall),      32'd0);
        chk({tag, "/wr"},     32'(dmem_wr),    32'd0);
        chk({tag, "/wben"},   32'(wb_en),      32'd0);
        chk({tag, "/wbaddr"}, 32'(wb_addr),    32'd0);
        chk({tag, "/wbdata"}, 32'(wb_data),    32'd0);
        chk({tag, "/pcl"},    32'(pc_load),    32'd0);
        chk({tag, "/pcv"},    pc_value,        32'd0);
        chk({tag, "/fl"},     32'(flags_load), 32'd0);
        chk({tag, "/flags"},  32'(flags_out),  32'd0);
    endtask

    // Present a lone PUSH without clocking it: the address shown is the live SP
    task automatic probe_sp(input string tag);
        ctl_t c;
        c = '0; c.push = 1'b1;
        drive(c, 16'h0, 16'h0, 16'h0, 32'h0, 3'd0, 3'd0);
        #1;
        chk({tag, "/sp"}, 32'(dmem_addr), 32'(ref_sp));
        idle_inputs();
        @(posedge clk); #1;
    endtask

    // One instruction: model predicts per-cycle memory accesses and final MEM/WB state
    task automatic exec(input ctl_t c, input logic [15:0] alu, input logic [15:0] rsrc,
                        input logic [15:0] inp, input logic [31:0] npc,
                        input logic [2:0] rdst, input logic [2:0] flg, input string tag);
        logic [AW-1:0] ea[$];
        logic          ew[$];
        logic [15:0]   ed[$];
        logic [AW-1:0] s, a20;
        logic          x_wben, x_pcl, x_fl;
        logic [15:0]   x_wbdata;
        logic [31:0]   x_pc;
        logic [2:0]    x_flags;
        logic [15:0]   fw;
        s = ref_sp; a20 = AW'(alu);
        x_wben = 1'b0; x_wbdata = alu; x_pcl = 1'b0; x_fl = 1'b0; x_pc = '0; x_flags = '0;
        if (c.rti) begin
            fw = mrd(s + 20'd1);
            x_pc = {mrd(s + 20'd3), mrd(s + 20'd2)};
            x_flags = fw[2:0]; x_pcl = 1'b1; x_fl = 1'b1;
            for (int k = 1; k <= 3; k++) begin ea.push_back(s + AW'(k)); ew.push_back(1'b0); ed.push_back(16'h0); end
            ref_sp = s + 20'd3;
        end else if (c.ret) begin
            x_pc = {mrd(s + 20'd2), mrd(s + 20'd1)};
            x_pcl = 1'b1;
            for (int k = 1; k <= 2; k++) begin ea.push_back(s + AW'(k)); ew.push_back(1'b0); ed.push_back(16'h0); end
            ref_sp = s + 20'd2;
        end else if (c.intcall || c.call) begin
            ea.push_back(s);          ew.push_back(1'b1); ed.push_back(npc[31:16]);
            ea.push_back(s - 20'd1);  ew.push_back(1'b1); ed.push_back(npc[15:0]);
            if (c.intcall) begin
                ea.push_back(s - 20'd2); ew.push_back(1'b1); ed.push_back({13'b0, flg});
            end
            foreach (ea[k]) ref_mem[ea[k]] = ed[k];
            ref_sp = s - AW'(ea.size());
        end else if (c.push) begin
            ea.push_back(s); ew.push_back(1'b1); ed.push_back(rsrc);
            ref_mem[s] = rsrc; ref_sp = s - 20'd1; x_wben = c.wbin;
        end else if (c.pop) begin
            ea.push_back(s + 20'd1); ew.push_back(1'b0); ed.push_back(16'h0);
            x_wbdata = mrd(s + 20'd1); ref_sp = s + 20'd1; x_wben = c.wbin;
        end else if (c.std) begin
            ea.push_back(a20); ew.push_back(1'b1); ed.push_back(rsrc);
            ref_mem[a20] = rsrc; x_wben = c.wbin;
        end else begin
            ea.push_back(a20); ew.push_back(1'b0); ed.push_back(16'h0);
            if (c.ldd)       x_wbdata = mrd(a20);
            else if (c.in_c) x_wbdata = inp;
            x_wben = c.wbin;
        end

        drive(c, alu, rsrc, inp, npc, rdst, flg);
        for (int k = 0; k < ea.size(); k++) begin
            #1;
            chk($sformatf("%s/c%0d/stall", tag, k), 32'(stall), 32'(k != ea.size() - 1));
            chk($sformatf("%s/c%0d/addr", tag, k), 32'(dmem_addr), 32'(ea[k]));
            chk($sformatf("%s/c%0d/wr", tag, k), 32'(dmem_wr), 32'(ew[k]));
            if (ew[k]) chk($sformatf("%s/c%0d/wdata", tag, k), 32'(dmem_wdata), 32'(ed[k]));
            @(posedge clk); #1;
        end
        idle_inputs();

        chk({tag, "/wben"}, 32'(wb_en), 32'(x_wben));
        if (x_wben) begin
            chk({tag, "/wbaddr"}, 32'(wb_addr), 32'(rdst));
            chk({tag, "/wbdata"}, 32'(wb_data), 32'(x_wbdata));
        end
        chk({tag, "/pcl"}, 32'(pc_load), 32'(x_pcl));
        if (x_pcl) chk({tag, "/pcv"}, pc_value, x_pc);
        chk({tag, "/fl"}, 32'(flags_load), 32'(x_fl));
        if (x_fl) chk({tag, "/flags"}, 32'(flags_out), 32'(x_flags));
        foreach (ea[k]) if (ew[k]) chk($sformatf("%s/mem%0d", tag, k), 32'(mem[ea[k]]), 32'(ed[k]));
    endtask

    initial begin
        ctl_t c;
        rst_n = 1'b0;
        idle_inputs();
        ref_sp = SP0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst0");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        probe_sp("rst0");

        // Reset asserted while CALL is in its second cycle: op abandoned
        c = '0; c.call = 1'b1;
        drive(c, 16'h0, 16'h0, 16'h0, 32'hAAAA_5555, 3'd0, 3'd0);
        @(posedge clk); #1;
        chk("t1/it2_stall", 32'(stall), 32'd0);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_zero("t1a");
        @(posedge clk); #1;
        check_zero("t1b");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        ref_sp = SP0;
        ref_mem[SP0] = 16'hAAAA;
        chk("t1/mem_hi", 32'(mem[SP0]), 32'h0000_AAAA);
        chk("t1/mem_lo_abandoned", 32'(mem[20'hFFFFD]), 32'h0);
        probe_sp("t1");

        // STD then LDD of the same address
        c = '0; c.std = 1'b1;
        exec(c, 16'h0040, 16'hBEEF, 16'h0, 32'h0, 3'd1, 3'd0, "t2_std");
        c = '0; c.ldd = 1'b1; c.wbin = 1'b1;
        exec(c, 16'h0040, 16'h0, 16'h0, 32'h0, 3'd3, 3'd0, "t2_ldd");

        // CALL / RET
        c = '0; c.call = 1'b1;
        exec(c, 16'h0, 16'h0, 16'h0, 32'h0001_2345, 3'd0, 3'd0, "t3_call");
        probe_sp("t3_call");
        c = '0; c.ret = 1'b1;
        exec(c, 16'h0, 16'h0, 16'h0, 32'h0, 3'd0, 3'd0, "t3_ret");
        probe_sp("t3_ret");

        // INTCALL / RTI
        c = '0; c.intcall = 1'b1;
        exec(c, 16'h0, 16'h0, 16'h0, 32'hCAFE_0777, 3'd0, 3'b101, "t4_intcall");
        probe_sp("t4_intcall");
        c = '0; c.rti = 1'b1;
        exec(c, 16'h0, 16'h0, 16'h0, 32'h0, 3'd0, 3'd0, "t4_rti");
        probe_sp("t4_rti");

        // POP across the top of the address space, then PUSH/POP round trip
        c = '0; c.pop = 1'b1; c.wbin = 1'b1;
        exec(c, 16'h0, 16'h0, 16'h0, 32'h0, 3'd2, 3'd0, "t5_pop1");
        probe_sp("t5_pop1");
        exec(c, 16'h0, 16'h0, 16'h0, 32'h0, 3'd2, 3'd0, "t5_popwrap");
        probe_sp("t5_popwrap");
        c = '0; c.push = 1'b1;
        exec(c, 16'h0, 16'h1234, 16'h0, 32'h0, 3'd0, 3'd0, "t5_push");
        c = '0; c.pop = 1'b1; c.wbin = 1'b1;
        exec(c, 16'h0, 16'h0, 16'h0, 32'h0, 3'd5, 3'd0, "t5_pop2");
        probe_sp("t5_pop2");

        // PUSH and POP together: push wins
        c = '0; c.push = 1'b1; c.pop = 1'b1; c.wbin = 1'b1;
        exec(c, 16'h5A5A, 16'h0A0A, 16'h0, 32'h0, 3'd6, 3'd0, "t6_pushpop");
        probe_sp("t6");

        // IN port
        c = '0; c.in_c = 1'b1; c.wbin = 1'b1;
        exec(c, 16'h1111, 16'h0, 16'h7E57, 32'h0, 3'd7, 3'd0, "t7_in");

        // Randomized mixes, including simultaneous controls
        for (int n = 0; n < 150; n++) begin
            c = '0;
            c.rti     = ($urandom_range(0, 9) == 0);
            c.ret     = ($urandom_range(0, 7) == 0);
            c.intcall = ($urandom_range(0, 9) == 0);
            c.call    = ($urandom_range(0, 7) == 0);
            c.push    = ($urandom_range(0, 3) == 0);
            c.pop     = ($urandom_range(0, 3) == 0);
            c.std     = ($urandom_range(0, 4) == 0);
            c.ldd     = ($urandom_range(0, 4) == 0);
            if ({c.rti, c.ret, c.intcall, c.call, c.push, c.pop, c.std, c.ldd} == 8'h00)
                c.in_c = 1'($urandom_range(0, 1));
            c.wbin = 1'($urandom_range(0, 1));
            exec(c, 16'($urandom), 16'($urandom), 16'($urandom), $urandom,
                 3'($urandom), 3'($urandom), $sformatf("rnd%0d", n));
        end
        probe_sp("rnd_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
